cp0_exception_unit: RTL and testbench

// - Coprocessor-0 / exception unit: consumes the decoder's sys, exce_ret, mfc0 and mtc0 strobes.
// - Holds STATUS/CAUSE/EPC, latches external interrupts, decides when to trap, and drives PC redirect.
// - Sits beside the PC/regfile: redirect overrides next PC, rdata feeds the mfc0 writeback mux.

---
 rtl/cp0_exception_unit.sv | 163 ++++++++++++++++
 tb/tb_cp0_exception_unit.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exception_unit.sv
// Coprocessor-0 exception unit. It holds STATUS, CAUSE and EPC, latches the
// external interrupt lines, decides when to trap or return, and drives the PC
// redirect plus the mfc0 read data.
// The RUN/HANDLER state doubles as STATUS.EXL and is visible on in_handler.
// There is no handshake here: every action is qualified by en, which is high
// only when the instruction at pc really commits in this cycle.
module cp0_exception_unit #(
    parameter int          IRQ_NUM      = 3,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               sys,
    input  logic               exce_ret,
    input  logic               mfc0,
    input  logic               mtc0,
    input  logic [4:0]         cp0_sel,
    input  logic [31:0]        wdata,
    input  logic [31:0]        pc,
    input  logic [IRQ_NUM-1:0] irq,
    output logic [31:0]        rdata,
    output logic               redirect,
    output logic [31:0]        redirect_pc,
    output logic               in_handler,
    output logic [IRQ_NUM-1:0] pending
);

    localparam logic [4:0] SEL_STATUS = 5'd12;
    localparam logic [4:0] SEL_CAUSE  = 5'd13;
    localparam logic [4:0] SEL_EPC    = 5'd14;
    localparam logic [4:0] EXC_INT    = 5'd0;
    localparam logic [4:0] EXC_SYS    = 5'd8;

    typedef enum logic {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } state_t;

    state_t             state, state_next;
    logic               ie, ie_next;
    logic [IRQ_NUM-1:0] im, im_next;
    logic [4:0]         exc_code, exc_code_next;
    logic [31:0]        epc, epc_next;

    logic [IRQ_NUM-1:0] irq_s1, irq_s2, irq_d;
    logic [IRQ_NUM-1:0] irq_rise, ip_clear, pending_next;
    logic               exl, int_req;
    logic               take_sys, take_int, take_eret, mtc0_ok;
    logic [31:0]        status_val, cause_val;

    assign exl        = (state == HANDLER);
    assign in_handler = exl;

    // Interrupts are only taken in RUN. sys beats a pending interrupt in the same cycle.
    assign int_req   = ie & ~exl & (|(pending & im));
    assign take_sys  = en & sys & ~exl;
    assign take_int  = en & int_req & ~sys;
    assign take_eret = en & exce_ret & exl;

    // A trapped instruction is squashed, so any mtc0 it carries must not land.
    assign mtc0_ok = en & mtc0 & ~take_sys & ~take_int;

    // IP bits are write-one-to-clear. A new edge in the same cycle wins over the clear.
    assign irq_rise     = irq_s2 & ~irq_d;
    assign ip_clear     = (mtc0_ok && (cp0_sel == SEL_CAUSE)) ? wdata[8 +: IRQ_NUM] : '0;
    assign pending_next = (pending & ~ip_clear) | irq_rise;

    // Two-flop synchronizer, edge-detect delay flop and sticky pending bits (not gated by en).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_s1  <= '0;
            irq_s2  <= '0;
            irq_d   <= '0;
            pending <= '0;
        end else begin
            irq_s1  <= irq;
            irq_s2  <= irq_s1;
            irq_d   <= irq_s2;
            pending <= pending_next;
        end
    end

    // Architectural CP0 registers and the RUN/HANDLER state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            ie       <= 1'b0;
            im       <= '0;
            exc_code <= '0;
            epc      <= '0;
        end else begin
            state    <= state_next;
            ie       <= ie_next;
            im       <= im_next;
            exc_code <= exc_code_next;
            epc      <= epc_next;
        end
    end

    // Next-state logic: mtc0 writes first, then trap or return overrides, plus the redirect.
    always_comb begin
        state_next    = state;
        ie_next       = ie;
        im_next       = im;
        exc_code_next = exc_code;
        epc_next      = epc;
        redirect      = 1'b0;
        redirect_pc   = '0;

        if (mtc0_ok) begin
            case (cp0_sel)
                SEL_STATUS: begin
                    ie_next    = wdata[0];
                    state_next = wdata[1] ? HANDLER : RUN;
                    im_next    = wdata[8 +: IRQ_NUM];
                end
                SEL_EPC: epc_next = {wdata[31:2], 2'b00};
                default: ;
            endcase
        end

        if (take_sys) begin
            redirect      = 1'b1;
            redirect_pc   = HANDLER_ADDR;
            epc_next      = pc + 32'd4;
            exc_code_next = EXC_SYS;
            state_next    = HANDLER;
        end else if (take_int) begin
            // The interrupted instruction is re-executed after eret, so EPC is pc itself.
            redirect      = 1'b1;
            redirect_pc   = HANDLER_ADDR;
            epc_next      = pc;
            exc_code_next = EXC_INT;
            state_next    = HANDLER;
        end else if (take_eret) begin
            redirect    = 1'b1;
            redirect_pc = epc;
            state_next  = RUN;
        end
    end

    // Register images as software sees them, and the mfc0 read mux.
    always_comb begin
        status_val                 = '0;
        status_val[0]              = ie;
        status_val[1]              = exl;
        status_val[8 +: IRQ_NUM]   = im;
        cause_val                  = '0;
        cause_val[6:2]             = exc_code;
        cause_val[8 +: IRQ_NUM]    = pending;
        rdata                      = '0;
        if (mfc0) begin
            case (cp0_sel)
                SEL_STATUS: rdata = status_val;
                SEL_CAUSE:  rdata = cause_val;
                SEL_EPC:    rdata = epc;
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Bench for cp0_exception_unit. Each task drives one scenario. Expected values
// go into exp_q when the stimulus is driven and are popped when the DUT output is sampled.
module tb_cp0_exception_unit;

    localparam int IRQ_NUM = 3;
    localparam logic [4:0] SEL_STATUS = 5'd12;
    localparam logic [4:0] SEL_CAUSE  = 5'd13;
    localparam logic [4:0] SEL_EPC    = 5'd14;

    logic               clk = 1'b0;
    logic               rst;
    logic               en, sys, exce_ret, mfc0, mtc0;
    logic [4:0]         cp0_sel;
    logic [31:0]        wdata, pc;
    logic [IRQ_NUM-1:0] irq;
    logic [31:0]        rdata;
    logic               redirect;
    logic [31:0]        redirect_pc;
    logic               in_handler;
    logic [IRQ_NUM-1:0] pending;

    logic [31:0] exp_q[$];
    logic [31:0] exp_v;
    logic [31:0] got;
    int          n_cmp = 0;
    int          n_err = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1);
    end

    cp0_exception_unit #(.IRQ_NUM(IRQ_NUM), .HANDLER_ADDR(32'h0000_0080)) dut (
        .clk(clk), .rst(rst), .en(en), .sys(sys), .exce_ret(exce_ret),
        .mfc0(mfc0), .mtc0(mtc0), .cp0_sel(cp0_sel), .wdata(wdata), .pc(pc),
        .irq(irq), .rdata(rdata), .redirect(redirect), .redirect_pc(redirect_pc),
        .in_handler(in_handler), .pending(pending)
    );

    // ---------------- driver tasks ----------------
    task automatic idle();
        en = 1'b0; sys = 1'b0; exce_ret = 1'b0; mfc0 = 1'b0; mtc0 = 1'b0;
        cp0_sel = '0; wdata = '0; pc = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_cp0(input logic [4:0] sel, output logic [31:0] val);
        mfc0 = 1'b1; cp0_sel = sel;
        #1;
        val = rdata;
        mfc0 = 1'b0; cp0_sel = '0;
    endtask

    task automatic write_cp0(input logic [4:0] sel, input logic [31:0] data);
        @(negedge clk);
        idle();
        en = 1'b1; mtc0 = 1'b1; cp0_sel = sel; wdata = data;
        step();
        idle();
    endtask

    task automatic wait_edges(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; irq = '0; idle();
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        repeat (2) @(posedge clk);
        #1;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(in_handler) !== exp_v) begin n_err++; $display("FAIL reset_in_handler: got %h expected %h", in_handler, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(pending) !== exp_v) begin n_err++; $display("FAIL reset_pending: got %h expected %h", pending, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(redirect) !== exp_v) begin n_err++; $display("FAIL reset_redirect: got %h expected %h", redirect, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (redirect_pc !== exp_v) begin n_err++; $display("FAIL reset_redirect_pc: got %h expected %h", redirect_pc, exp_v); end
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(32'h0);
        read_cp0(SEL_EPC, got);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (got !== exp_v) begin n_err++; $display("FAIL reset_epc: got %h expected %h", got, exp_v); end
    endtask

    task automatic test_syscall();
        @(negedge clk);
        idle(); en = 1'b1; sys = 1'b1; pc = 32'h100;
        exp_q.push_back(32'h1); exp_q.push_back(32'h80);
        exp_q.push_back(32'h104); exp_q.push_back(32'd8); exp_q.push_back(32'h1);
        #1;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(redirect) !== exp_v) begin n_err++; $display("FAIL sys_redirect: got %h expected %h", redirect, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (redirect_pc !== exp_v) begin n_err++; $display("FAIL sys_redirect_pc: got %h expected %h", redirect_pc, exp_v); end
        step(); idle();
        read_cp0(SEL_EPC, got);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (got !== exp_v) begin n_err++; $display("FAIL sys_epc: got %h expected %h", got, exp_v); end
        read_cp0(SEL_CAUSE, got);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(got[6:2]) !== exp_v) begin n_err++; $display("FAIL sys_exccode: got %h expected %h", got[6:2], exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(in_handler) !== exp_v) begin n_err++; $display("FAIL sys_in_handler: got %h expected %h", in_handler, exp_v); end
        // sys while already in HANDLER is ignored
        @(negedge clk);
        idle(); en = 1'b1; sys = 1'b1; pc = 32'h500;
        exp_q.push_back(32'h0); exp_q.push_back(32'h104);
        #1;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(redirect) !== exp_v) begin n_err++; $display("FAIL sys_in_handler_redirect: got %h expected %h", redirect, exp_v); end
        step(); idle();
        read_cp0(SEL_EPC, got);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (got !== exp_v) begin n_err++; $display("FAIL sys_in_handler_epc: got %h expected %h", got, exp_v); end
    endtask

    task automatic test_eret();
        @(negedge clk);
        idle(); en = 1'b1; exce_ret = 1'b1; pc = 32'h84;
        exp_q.push_back(32'h1); exp_q.push_back(32'h104); exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(redirect) !== exp_v) begin n_err++; $display("FAIL eret_redirect: got %h expected %h", redirect, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (redirect_pc !== exp_v) begin n_err++; $display("FAIL eret_redirect_pc: got %h expected %h", redirect_pc, exp_v); end
        step(); idle();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(in_handler) !== exp_v) begin n_err++; $display("FAIL eret_in_handler: got %h expected %h", in_handler, exp_v); end
        // eret while in RUN does nothing
        @(negedge clk);
        idle(); en = 1'b1; exce_ret = 1'b1; pc = 32'h108;
        exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(redirect) !== exp_v) begin n_err++; $display("FAIL eret_in_run_redirect: got %h expected %h", redirect, exp_v); end
        step(); idle();
    endtask

    task automatic test_interrupt();
        write_cp0(SEL_STATUS, 32'h101);
        exp_q.push_back(32'h101);
        read_cp0(SEL_STATUS, got);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (got !== exp_v) begin n_err++; $display("FAIL int_status: got %h expected %h", got, exp_v); end
        @(negedge clk);
        irq = 3'b001;
        exp_q.push_back(32'h0); exp_q.push_back(32'h1);
        wait_edges(2);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(pending) !== exp_v) begin n_err++; $display("FAIL int_pending_edge2: got %h expected %h", pending, exp_v); end
        step();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(pending) !== exp_v) begin n_err++; $display("FAIL int_pending_edge3: got %h expected %h", pending, exp_v); end
        // request present but no commit: nothing happens
        @(negedge clk);
        idle(); sys = 1'b1; pc = 32'h1fc;
        exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(redirect) !== exp_v) begin n_err++; $display("FAIL int_en0_redirect: got %h expected %h", redirect, exp_v); end
        step();
        @(negedge clk);
        idle(); en = 1'b1; pc = 32'h200;
        exp_q.push_back(32'h80); exp_q.push_back(32'h200); exp_q.push_back(32'h1);
        #1;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (redirect_pc !== exp_v) begin n_err++; $display("FAIL int_redirect_pc: got %h expected %h", redirect_pc, exp_v); end
        step(); idle();
        read_cp0(SEL_EPC, got);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (got !== exp_v) begin n_err++; $display("FAIL int_epc: got %h expected %h", got, exp_v); end
        read_cp0(SEL_CAUSE, got);
        exp_v = exp_q.pop_front(); n_cmp++;
        if ({27'd0, got[6:2]} !== 32'd0 || 32'(got[8]) !== exp_v) begin
            n_err++; $display("FAIL int_cause: got %h expected exccode 0 ip0 %h", got, exp_v);
        end
        write_cp0(SEL_CAUSE, 32'h100);
        @(negedge clk);
        idle(); en = 1'b1; exce_ret = 1'b1;
        step(); idle();
    endtask

    task automatic test_masking_priority();
        write_cp0(SEL_STATUS, 32'h001);
        @(negedge clk);
        irq = 3'b011;
        exp_q.push_back(32'h2);
        wait_edges(3);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(pending) !== exp_v) begin n_err++; $display("FAIL mask_pending: got %h expected %h", pending, exp_v); end
        @(negedge clk);
        idle(); en = 1'b1; pc = 32'h400;
        exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(redirect) !== exp_v) begin n_err++; $display("FAIL mask_im0_redirect: got %h expected %h", redirect, exp_v); end
        step();
        write_cp0(SEL_STATUS, 32'h200);
        @(negedge clk);
        idle(); en = 1'b1; pc = 32'h404;
        exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(redirect) !== exp_v) begin n_err++; $display("FAIL mask_ie0_redirect: got %h expected %h", redirect, exp_v); end
        step();
        // enabling write: the interrupt still sees the old IE in this cycle
        @(negedge clk);
        idle(); en = 1'b1; mtc0 = 1'b1; cp0_sel = SEL_STATUS; wdata = 32'h201;
        exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(redirect) !== exp_v) begin n_err++; $display("FAIL mask_old_ie_redirect: got %h expected %h", redirect, exp_v); end
        step();
        // sys and interrupt together: syscall wins
        @(negedge clk);
        idle(); en = 1'b1; sys = 1'b1; pc = 32'h600;
        exp_q.push_back(32'h604); exp_q.push_back(32'd8);
        step(); idle();
        read_cp0(SEL_EPC, got);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (got !== exp_v) begin n_err++; $display("FAIL prio_epc: got %h expected %h", got, exp_v); end
        read_cp0(SEL_CAUSE, got);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(got[6:2]) !== exp_v) begin n_err++; $display("FAIL prio_exccode: got %h expected %h", got[6:2], exp_v); end
        @(negedge clk);
        idle(); en = 1'b1; exce_ret = 1'b1;
        step(); idle();
        // interrupt squashes the mtc0 it lands on
        @(negedge clk);
        idle(); en = 1'b1; mtc0 = 1'b1; cp0_sel = SEL_EPC; wdata = 32'h1234; pc = 32'h700;
        exp_q.push_back(32'h1); exp_q.push_back(32'h700); exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(redirect) !== exp_v) begin n_err++; $display("FAIL squash_redirect: got %h expected %h", redirect, exp_v); end
        step(); idle();
        read_cp0(SEL_EPC, got);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (got !== exp_v) begin n_err++; $display("FAIL squash_epc: got %h expected %h", got, exp_v); end
        read_cp0(SEL_CAUSE, got);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(got[6:2]) !== exp_v) begin n_err++; $display("FAIL squash_exccode: got %h expected %h", got[6:2], exp_v); end
        write_cp0(SEL_CAUSE, 32'h200);
        @(negedge clk);
        idle(); en = 1'b1; exce_ret = 1'b1;
        exp_q.push_back(32'h700);
        #1;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (redirect_pc !== exp_v) begin n_err++; $display("FAIL squash_eret_pc: got %h expected %h", redirect_pc, exp_v); end
        step(); idle();
        write_cp0(SEL_STATUS, 32'h0);
    endtask

    task automatic test_w1c();
        @(negedge clk);
        irq = 3'b111;
        wait_edges(3);
        @(negedge clk);
        irq = 3'b110;
        wait_edges(3);
        @(negedge clk);
        irq = 3'b111;
        exp_q.push_back(32'h5); exp_q.push_back(32'h4);
        wait_edges(3);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(pending) !== exp_v) begin n_err++; $display("FAIL w1c_set: got %h expected %h", pending, exp_v); end
        write_cp0(SEL_CAUSE, 32'h100);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(pending) !== exp_v) begin n_err++; $display("FAIL w1c_clear: got %h expected %h", pending, exp_v); end
        // clear lands on the same edge as a new rising edge: the set wins
        @(negedge clk);
        irq = 3'b110;
        wait_edges(3);
        @(negedge clk);
        irq = 3'b111;
        exp_q.push_back(32'h5);
        wait_edges(2);
        write_cp0(SEL_CAUSE, 32'h100);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(pending) !== exp_v) begin n_err++; $display("FAIL w1c_set_wins: got %h expected %h", pending, exp_v); end
        // ExcCode bits are read-only; last trap was an interrupt
        write_cp0(SEL_CAUSE, 32'h77c);
        exp_q.push_back(32'h0);
        read_cp0(SEL_CAUSE, got);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (got !== exp_v) begin n_err++; $display("FAIL w1c_cause_after_clear: got %h expected %h", got, exp_v); end
    endtask

    task automatic test_epc_and_reads();
        write_cp0(SEL_EPC, 32'h7);
        exp_q.push_back(32'h4); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        read_cp0(SEL_EPC, got);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (got !== exp_v) begin n_err++; $display("FAIL epc_write_align: got %h expected %h", got, exp_v); end
        read_cp0(5'd15, got);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (got !== exp_v) begin n_err++; $display("FAIL read_bad_sel: got %h expected %h", got, exp_v); end
        cp0_sel = SEL_EPC; mfc0 = 1'b0;
        #1;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (rdata !== exp_v) begin n_err++; $display("FAIL read_mfc0_low: got %h expected %h", rdata, exp_v); end
        cp0_sel = '0;
        // writing EXL through STATUS moves the state directly
        write_cp0(SEL_STATUS, 32'h2);
        exp_q.push_back(32'h1); exp_q.push_back(32'h4);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(in_handler) !== exp_v) begin n_err++; $display("FAIL mtc0_exl_set: got %h expected %h", in_handler, exp_v); end
        @(negedge clk);
        idle(); en = 1'b1; exce_ret = 1'b1;
        #1;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (redirect_pc !== exp_v) begin n_err++; $display("FAIL mtc0_exl_eret_pc: got %h expected %h", redirect_pc, exp_v); end
        step(); idle();
        // pc + 4 wraps around
        @(negedge clk);
        idle(); en = 1'b1; sys = 1'b1; pc = 32'hffff_fffc;
        exp_q.push_back(32'h0);
        step(); idle();
        read_cp0(SEL_EPC, got);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (got !== exp_v) begin n_err++; $display("FAIL wrap_epc: got %h expected %h", got, exp_v); end
        @(negedge clk);
        idle(); en = 1'b1; exce_ret = 1'b1;
        step(); idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] p;
        for (int i = 0; i < 8; i++) begin
            p = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
            @(negedge clk);
            idle(); en = 1'b1; sys = 1'b1; pc = p;
            exp_q.push_back(32'h80);
            exp_q.push_back(p + 32'd4);
            #1;
            exp_v = exp_q.pop_front(); n_cmp++;
            if (redirect_pc !== exp_v) begin n_err++; $display("FAIL b2b_sys_pc[%0d]: got %h expected %h", i, redirect_pc, exp_v); end
            @(negedge clk);
            idle(); en = 1'b1; exce_ret = 1'b1; pc = 32'h80;
            #1;
            exp_v = exp_q.pop_front(); n_cmp++;
            if (redirect_pc !== exp_v) begin n_err++; $display("FAIL b2b_eret_pc[%0d]: got %h expected %h", i, redirect_pc, exp_v); end
        end
        step(); idle();
        exp_q.push_back(32'h0);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(in_handler) !== exp_v) begin n_err++; $display("FAIL b2b_final_state: got %h expected %h", in_handler, exp_v); end
    endtask

    task automatic test_reset_mid_handler();
        @(negedge clk);
        irq = 3'b000;
        wait_edges(3);
        @(negedge clk);
        irq = 3'b001;
        wait_edges(3);
        @(negedge clk);
        idle(); en = 1'b1; sys = 1'b1; pc = 32'h900;
        step(); idle();
        exp_q.push_back(32'h1); exp_q.push_back(32'h1);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(in_handler) !== exp_v) begin n_err++; $display("FAIL rst_pre_in_handler: got %h expected %h", in_handler, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(pending) !== exp_v) begin n_err++; $display("FAIL rst_pre_pending: got %h expected %h", pending, exp_v); end
        @(negedge clk);
        #2 rst = 1'b1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(in_handler) !== exp_v) begin n_err++; $display("FAIL rst_mid_in_handler: got %h expected %h", in_handler, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(pending) !== exp_v) begin n_err++; $display("FAIL rst_mid_pending: got %h expected %h", pending, exp_v); end
        read_cp0(SEL_EPC, got);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (got !== exp_v) begin n_err++; $display("FAIL rst_mid_epc: got %h expected %h", got, exp_v); end
        @(negedge clk);
        rst = 1'b0;
        irq = 3'b000;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_syscall();
        test_eret();
        test_interrupt();
        test_masking_priority();
        test_w1c();
        test_epc_and_reads();
        test_back_to_back();
        test_reset_mid_handler();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
